ex_mem_skid: RTL and testbench

Parametrised successor to the EX/MEM pipeline latch: carries the register-writeback and memory-access fields from execute to memory stage through a 2-entry elastic (skid) buffer with a valid/ready handshake on both sides, plus a synchronous flush. It replaces the single stall-bit hold scheme so that a memory-stage backpressure never needs a combinational path back into execute.

---
 rtl/ex_mem_skid.sv | 121 ++++++++++++
 tb/tb_ex_mem_skid.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline latch built as a 2-entry skid buffer with valid/ready on both sides.
// Handshake outputs and payload come straight from flops; bubbles present NOP_ALUOP and zeros.
module ex_mem_skid #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_ADDR_W = 32,
    parameter int unsigned ALUOP_W    = 8,
    parameter logic [ALUOP_W-1:0] NOP_ALUOP = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_w_addr,
    input  logic                  in_w_req,
    input  logic [DATA_W-1:0]     in_w_data,
    input  logic [MEM_ADDR_W-1:0] in_mem_addr,
    input  logic [ALUOP_W-1:0]    in_aluop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_w_addr,
    output logic                  out_w_req,
    output logic [DATA_W-1:0]     out_w_data,
    output logic [MEM_ADDR_W-1:0] out_mem_addr,
    output logic [ALUOP_W-1:0]    out_aluop,
    output logic [1:0]            count
);

    localparam int unsigned ENTRY_W = REG_ADDR_W + 1 + DATA_W + MEM_ADDR_W + ALUOP_W;
    localparam int unsigned ZERO_W  = ENTRY_W - ALUOP_W;
    localparam logic [ENTRY_W-1:0] BUBBLE = {{ZERO_W{1'b0}}, NOP_ALUOP};

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [ENTRY_W-1:0]   head_q, head_d;
    logic [ENTRY_W-1:0]   skid_q, skid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 take_in;
    logic                 give_out;
    logic [ENTRY_W-1:0]   in_entry;

    assign in_entry = {in_w_addr, in_w_req, in_w_data, in_mem_addr, in_aluop};

    // Next-state, storage steering and handshake flop inputs.
    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        skid_d   = skid_q;
        take_in  = rdy & in_valid & in_ready_q & ~flush;
        give_out = rdy & out_valid_q & out_ready;

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (take_in) begin
                        head_d  = in_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (take_in && give_out) begin
                        head_d = in_entry;
                    end else if (give_out) begin
                        state_d = ST_EMPTY;
                    end else if (take_in) begin
                        skid_d  = in_entry;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (give_out) begin
                        head_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        // An empty buffer shows a clean bubble, never a stale entry.
        if (state_d == ST_EMPTY) begin
            head_d = BUBBLE;
        end

        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            head_q      <= BUBBLE;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign {out_w_addr, out_w_req, out_w_data, out_mem_addr, out_aluop} = head_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign count     = 2'(state_q);

endmodule

// File: tb/tb_ex_mem_skid.sv
// Bench for ex_mem_skid: directed vector table plus randomised traffic, both checked
// against a FIFO scoreboard of accepted entries.
module tb_ex_mem_skid;

    localparam logic [7:0] NOP = 8'h5A;

    typedef struct packed {
        logic [4:0]  w_addr;
        logic        w_req;
        logic [31:0] w_data;
        logic [31:0] mem_addr;
        logic [7:0]  aluop;
    } entry_t;

    typedef struct {
        logic       rst, rdy, fl, iv, ordy;
        logic [7:0] al;
        logic [1:0] c;
        logic       ir, ov;
        logic [7:0] oal;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, in_valid, in_ready, out_valid, out_ready;
    logic [4:0]  in_w_addr, out_w_addr;
    logic        in_w_req, out_w_req;
    logic [31:0] in_w_data, out_w_data, in_mem_addr, out_mem_addr;
    logic [7:0]  in_aluop, out_aluop;
    logic [1:0]  count;
    entry_t      out_e;
    entry_t      model[$];
    vec_t        vecs[$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    ex_mem_skid #(
        .REG_ADDR_W(5), .DATA_W(32), .MEM_ADDR_W(32), .ALUOP_W(8), .NOP_ALUOP(NOP)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_w_addr(in_w_addr), .in_w_req(in_w_req), .in_w_data(in_w_data),
        .in_mem_addr(in_mem_addr), .in_aluop(in_aluop),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_w_addr(out_w_addr), .out_w_req(out_w_req), .out_w_data(out_w_data),
        .out_mem_addr(out_mem_addr), .out_aluop(out_aluop),
        .count(count)
    );

    assign out_e = {out_w_addr, out_w_req, out_w_data, out_mem_addr, out_aluop};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic r, rd, fl, iv, ordy, input logic [7:0] al,
                       input logic [1:0] c, input logic ir, ov, input logic [7:0] oal);
        vec_t v;
        v.rst = r; v.rdy = rd; v.fl = fl; v.iv = iv; v.ordy = ordy; v.al = al;
        v.c = c; v.ir = ir; v.ov = ov; v.oal = oal;
        vecs.push_back(v);
    endtask

    // One clock: drive, pop/compare a predicted release, clock, update model, check state.
    task automatic cycle(input logic r, rd, fl, iv, ordy, input logic [7:0] al);
        entry_t e, h, exp_head;
        int     sz;
        logic   rel, acc;
        e.w_addr   = 5'($urandom);
        e.w_req    = 1'($urandom);
        e.w_data   = $urandom;
        e.mem_addr = $urandom;
        e.aluop    = al;
        rst = r; rdy = rd; flush = fl; in_valid = iv; out_ready = ordy;
        {in_w_addr, in_w_req, in_w_data, in_mem_addr, in_aluop} = e;
        sz  = model.size();
        rel = rd && !r && ordy && (sz != 0);
        acc = rd && !r && !fl && iv && (sz != 2);
        if (rel) begin
            h = model.pop_front();
            chk("pop", 128'(out_e), 128'(h));
        end
        @(posedge clk);
        #1;
        if (r || fl) model.delete();
        else if (acc) model.push_back(e);
        chk("count", 128'(count), 128'(model.size()));
        chk("in_ready", 128'(in_ready), 128'(model.size() != 2));
        chk("out_valid", 128'(out_valid), 128'(model.size() != 0));
        if (model.size() != 0) exp_head = model[0];
        else exp_head = {5'd0, 1'b0, 32'd0, 32'd0, NOP};
        chk("head", 128'(out_e), 128'(exp_head));
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_w_addr = '0; in_w_req = 1'b0; in_w_data = '0; in_mem_addr = '0; in_aluop = '0;

        //  rst rdy fl iv ordy al     count ir ov oal
        add(1, 1, 0, 0, 0, 8'h00, 2'd0, 1, 0, NOP);
        for (int i = 1; i <= 8; i++)
            add(0, 1, 0, 1, 1, 8'(i), 2'd1, 1, 1, 8'(i));
        add(0, 1, 0, 0, 1, 8'h00, 2'd0, 1, 0, NOP);
        // backpressure: A, B held, C waits
        add(0, 1, 0, 1, 0, 8'h0A, 2'd1, 1, 1, 8'h0A);
        add(0, 1, 0, 1, 0, 8'h0B, 2'd2, 0, 1, 8'h0A);
        add(0, 1, 0, 1, 0, 8'h0C, 2'd2, 0, 1, 8'h0A);
        add(0, 1, 0, 1, 1, 8'h0C, 2'd1, 1, 1, 8'h0B);
        add(0, 1, 0, 1, 1, 8'h0C, 2'd1, 1, 1, 8'h0C);
        add(0, 1, 0, 0, 1, 8'h00, 2'd0, 1, 0, NOP);
        // flush at count 2, then at count 1 with an acceptable input
        add(0, 1, 0, 1, 0, 8'h11, 2'd1, 1, 1, 8'h11);
        add(0, 1, 0, 1, 0, 8'h12, 2'd2, 0, 1, 8'h11);
        add(0, 1, 1, 1, 0, 8'h13, 2'd0, 1, 0, NOP);
        add(0, 1, 0, 1, 0, 8'h14, 2'd1, 1, 1, 8'h14);
        add(0, 1, 1, 1, 0, 8'h15, 2'd0, 1, 0, NOP);
        // rdy gating
        add(0, 0, 0, 1, 0, 8'h16, 2'd0, 1, 0, NOP);
        add(0, 1, 0, 1, 0, 8'h17, 2'd1, 1, 1, 8'h17);
        for (int i = 0; i < 3; i++)
            add(0, 0, 0, 1, 1, 8'h18, 2'd1, 1, 1, 8'h17);
        add(0, 1, 0, 1, 1, 8'h18, 2'd1, 1, 1, 8'h18);
        add(0, 1, 0, 0, 1, 8'h00, 2'd0, 1, 0, NOP);
        // flush acts with rdy low
        add(0, 1, 0, 1, 0, 8'h23, 2'd1, 1, 1, 8'h23);
        add(0, 0, 1, 1, 0, 8'h24, 2'd0, 1, 0, NOP);
        // reset from count 2
        add(0, 1, 0, 1, 0, 8'h25, 2'd1, 1, 1, 8'h25);
        add(0, 1, 0, 1, 0, 8'h26, 2'd2, 0, 1, 8'h25);
        add(1, 1, 0, 1, 0, 8'h27, 2'd0, 1, 0, NOP);
        add(0, 1, 0, 0, 0, 8'h00, 2'd0, 1, 0, NOP);
        // flush with a same-cycle release at count 2
        add(0, 1, 0, 1, 0, 8'h29, 2'd1, 1, 1, 8'h29);
        add(0, 1, 0, 1, 0, 8'h30, 2'd2, 0, 1, 8'h29);
        add(0, 1, 1, 1, 1, 8'h31, 2'd0, 1, 0, NOP);

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].rdy, vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].al);
            chk($sformatf("vec%0d_count", i), 128'(count), 128'(vecs[i].c));
            chk($sformatf("vec%0d_in_ready", i), 128'(in_ready), 128'(vecs[i].ir));
            chk($sformatf("vec%0d_out_valid", i), 128'(out_valid), 128'(vecs[i].ov));
            chk($sformatf("vec%0d_aluop", i), 128'(out_aluop), 128'(vecs[i].oal));
        end

        for (int i = 0; i < 1000; i++)
            cycle(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom));
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("drained", 128'(model.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
